// File: rtl/ultrasonic_echo_responder_if.sv
// Trigger/echo signal bundle between an ultrasonic controller (master) and
// the sensor emulator (slave).
interface ultrasonic_echo_responder_if #(
    parameter int CNT_W = 23
) ();
    logic             trigger;
    logic             obj_present;
    logic [CNT_W-1:0] echo_width;
    logic             echo;
    logic             busy;
    logic             short_trig;
    logic             meas_done;

    modport master (
        output trigger,
        output obj_present,
        output echo_width,
        input  echo,
        input  busy,
        input  short_trig,
        input  meas_done
    );

    modport slave (
        input  trigger,
        input  obj_present,
        input  echo_width,
        output echo,
        output busy,
        output short_trig,
        output meas_done
    );
endinterface

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04-style sensor emulator: qualifies a trigger pulse and answers with an
// echo pulse of programmed width after a fixed emulated burst delay.
module ultrasonic_echo_responder #(
    parameter int MIN_TRIG_CYCLES    = 1000,
    parameter int BURST_DELAY_CYCLES = 45000,
    parameter int TIMEOUT_CYCLES     = 3800000,
    parameter int HOLDOFF_CYCLES     = 100,
    parameter int CNT_W              = 23
) (
    input  logic                        clk,
    input  logic                        reset,
    ultrasonic_echo_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        DELAY,
        ECHO,
        HOLDOFF
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_TRIG   = CNT_W'(MIN_TRIG_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  =
        (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;

    // [0],[1] synchronise the asynchronous trigger; [2] is the edge-detect copy.
    logic [2:0]       trig_pipe_reg;
    logic             trig_s;
    logic             trig_q;
    logic             trig_rise;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] width_reg, width_next;
    logic [CNT_W-1:0] width_sel;
    logic             echo_reg, echo_next;
    logic             busy_reg, busy_next;
    logic             short_trig_reg, short_trig_next;
    logic             meas_done_reg, meas_done_next;

    assign trig_s    = trig_pipe_reg[1];
    assign trig_q    = trig_pipe_reg[2];
    assign trig_rise = trig_s & ~trig_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_pipe_reg <= '0;
        end else begin
            trig_pipe_reg <= {trig_pipe_reg[1:0], bus.trigger};
        end
    end

    // Width actually emitted: timeout when nothing is there, never zero, never
    // longer than the timeout.
    always_comb begin
        width_sel = bus.echo_width;
        if (!bus.obj_present) begin
            width_sel = TIMEOUT;
        end else if (bus.echo_width == '0) begin
            width_sel = CNT_ONE;
        end else if (bus.echo_width > TIMEOUT) begin
            width_sel = TIMEOUT;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        width_next      = width_reg;
        echo_next       = echo_reg;
        short_trig_next = 1'b0;
        meas_done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (trig_rise) begin
                    state_next = TRIG;
                    cnt_next   = CNT_ONE;
                end
            end
            TRIG: begin
                if (trig_s) begin
                    if (cnt_reg < MIN_TRIG) begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end else if (cnt_reg >= MIN_TRIG) begin
                    state_next = DELAY;
                    cnt_next   = '0;
                    width_next = width_sel;
                end else begin
                    state_next      = IDLE;
                    cnt_next        = '0;
                    short_trig_next = 1'b1;
                end
            end
            DELAY: begin
                if (cnt_reg >= BURST_LAST) begin
                    state_next = ECHO;
                    cnt_next   = CNT_ONE;
                    echo_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ECHO: begin
                if (cnt_reg >= width_reg) begin
                    state_next     = HOLDOFF;
                    cnt_next       = '0;
                    echo_next      = 1'b0;
                    meas_done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            HOLDOFF: begin
                if (cnt_reg >= HOLD_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                echo_next  = 1'b0;
            end
        endcase

        busy_next = (state_next == DELAY) || (state_next == ECHO) ||
                    (state_next == HOLDOFF);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            width_reg      <= '0;
            echo_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            short_trig_reg <= 1'b0;
            meas_done_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            width_reg      <= width_next;
            echo_reg       <= echo_next;
            busy_reg       <= busy_next;
            short_trig_reg <= short_trig_next;
            meas_done_reg  <= meas_done_next;
        end
    end

    assign bus.echo       = echo_reg;
    assign bus.busy       = busy_reg;
    assign bus.short_trig = short_trig_reg;
    assign bus.meas_done  = meas_done_reg;

endmodule

// File: doc/ultrasonic_echo_responder.md
# ultrasonic_echo_responder

Synthesisable responder for the HC-SR04-style trigger/echo protocol: qualifies a `trigger` pulse from an ultrasonic controller and returns an `echo` pulse whose width encodes a programmed distance, or the no-object timeout width. It sits in the test bench and in FPGA self-test builds in place of the physical sensor. It lets the ultrasonic controller, comparator and line-follower distance path be exercised with exact, repeatable echo widths.

## Interface
- `MIN_TRIG_CYCLES`, default 1000: minimum qualifying trigger high time (10 us at 100 MHz).
- `BURST_DELAY_CYCLES`, default 45000: emulated transmit-burst delay between trigger fall and echo rise.
- `TIMEOUT_CYCLES`, default 3800000: echo width when no object is present; also the clamp for `echo_width`.
- `HOLDOFF_CYCLES`, default 100: dead time after echo fall.
- `CNT_W`, default 23: counter and `echo_width` width.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-low reset.
- `trigger` in 1: trigger from the controller; asynchronous to `clk`.
- `obj_present` in 1: 1 selects `echo_width`; 0 selects `TIMEOUT_CYCLES`.
- `echo_width` in CNT_W: echo high time in cycles.
- `echo` out 1: registered echo pulse to the controller.
- `busy` out 1: high in DELAY, ECHO and HOLDOFF.
- `short_trig` out 1: one-cycle pulse when a trigger is rejected as too short.
- `meas_done` out 1: one-cycle pulse on the cycle `echo` falls.

## Operation
- **Synchroniser:** `trigger` passes through a 2-flop synchroniser to give `trig_s`; `trig_q` is the delayed copy of `trig_s`. Rise is `trig_s & ~trig_q`.
- **IDLE**
  - On a `trig_s` rise: go to TRIG with `cnt = 1`.
  - A `trig_s` that is already high on entry is not a rise; `trig_s` must go low first.
- **TRIG**
  - While `trig_s` = 1: `cnt++`, saturating at `MIN_TRIG_CYCLES`.
  - On `trig_s` = 0 with `cnt >= MIN_TRIG_CYCLES`: go to DELAY with `cnt = 0`, and latch `width`:
    - `obj_present` = 0: `width = TIMEOUT_CYCLES`.
    - `echo_width` = 0: `width = 1`.
    - `echo_width > TIMEOUT_CYCLES`: `width = TIMEOUT_CYCLES`.
    - Otherwise: `width = echo_width`.
  - On `trig_s` = 0 with `cnt < MIN_TRIG_CYCLES`: pulse `short_trig` for 1 cycle and go to IDLE.
- **DELAY:** count `BURST_DELAY_CYCLES` cycles. On the last one, go to ECHO, `echo <= 1`, `cnt = 1`.
- **ECHO**
  - `echo` stays high for exactly `width` cycles.
  - When `cnt == width`: `echo <= 0`, pulse `meas_done`, go to HOLDOFF with `cnt = 0`.
- **HOLDOFF:** hold for `HOLDOFF_CYCLES` cycles, then go to IDLE.
- **Ignored inputs:**
  - `trigger` is ignored in DELAY, ECHO and HOLDOFF.
  - `echo_width` and `obj_present` are sampled only at the TRIG→DELAY transition; later changes do not affect a measurement in progress.
- **Arithmetic:** all counters are CNT_W unsigned. Parameters must fit in CNT_W, with `TIMEOUT_CYCLES >= 1` and `BURST_DELAY_CYCLES >= 1`. No counter wraps.

## Timing
- **Reset values:** while `reset` = 0, immediately (asynchronously):
  - state = IDLE;
  - `echo`, `busy`, `short_trig`, `meas_done` = 0;
  - synchroniser flops and `cnt` = 0.
- **Reset mid-operation:** aborts the measurement with no `meas_done`. After release, a full new trigger is required.
- **Trigger length:** measured as the number of `clk` edges on which `trigger` is sampled high, ±0 cycles. The synchroniser delays rise and fall equally.
- **Echo rise latency:** let edge e0 be the first edge that samples `trigger` low. `echo` rises on edge e0 + `BURST_DELAY_CYCLES` + 2.
- **Echo fall:** `echo` falls exactly `width` edges after it rises. `meas_done` is high in the first cycle `echo` is low.
- **`short_trig`:** asserts on edge e0 + 2.
- **`busy`:** rises with the entry to DELAY, and falls on the edge HOLDOFF exits.
- **Back-to-back measurements:** the next qualifying trigger rise can be recognised the first cycle after `busy` falls.

## Test plan
Bench parameters: MIN_TRIG_CYCLES=10, BURST_DELAY_CYCLES=20, TIMEOUT_CYCLES=500, HOLDOFF_CYCLES=8, CNT_W=23.
- Trigger high 10 cycles, `obj_present`=1, `echo_width`=100 → `echo` rises 22 edges after e0 and is high exactly 100 cycles; one `meas_done` pulse; `busy` low 8 cycles after `echo` falls.
- Trigger high 9 cycles → `short_trig` pulses once at e0+2; `echo` and `busy` stay 0.
- `obj_present`=0, `echo_width`=100 → `echo` high 500 cycles. `echo_width`=0 → 1 cycle. `echo_width`=1000 → 500 cycles.
- Second trigger pulse during ECHO and during HOLDOFF → ignored, single echo. Trigger held high from ECHO through HOLDOFF exit → no new measurement until it falls and rises again.
- Change `echo_width` from 100 to 50 during DELAY → echo still 100 cycles. Next measurement uses 50.
- Assert `reset` mid-ECHO → `echo`/`busy` drop without waiting for `clk`, no `meas_done`. After release, a normal measurement yields the correct width.
